// File: rtl/wb_regfile_pkg.sv
// Shared constants and write-back select encoding for the write-back stage,
// reused by the decoder and forwarding unit.
package wb_regfile_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2
  } wb_sel_e;

  // Link has priority over a memory load; everything else writes the ALU result.
  function automatic wb_sel_e wb_sel_decode(input logic link, input logic store);
    if (link)  return WB_LINK;
    if (store) return WB_MEM;
    return WB_ALU;
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB pipeline-register outputs, decode read ports and commit/forwarding
// outputs of the write-back stage, bundled as one interface.
interface wb_regfile_if;
  import wb_regfile_pkg::*;

  logic              RegWrite;
  logic              IRegWrite;
  logic              IRegStore;
  logic              ILink;
  logic [DATA_W-1:0] IPCP2;
  logic [DATA_W-1:0] IALUResult;
  logic [DATA_W-1:0] IStoreMem;
  logic [ADDR_W-1:0] IRd;
  logic [ADDR_W-1:0] RsA;
  logic [ADDR_W-1:0] RsB;

  logic [DATA_W-1:0] ODataA;
  logic [DATA_W-1:0] ODataB;
  logic              OWBValid;
  logic [ADDR_W-1:0] OWBRd;
  logic [DATA_W-1:0] OWBData;
  logic [DATA_W-1:0] ORetired;

  modport master (
    output RegWrite, IRegWrite, IRegStore, ILink, IPCP2, IALUResult, IStoreMem,
           IRd, RsA, RsB,
    input  ODataA, ODataB, OWBValid, OWBRd, OWBData, ORetired
  );

  modport slave (
    input  RegWrite, IRegWrite, IRegStore, ILink, IPCP2, IALUResult, IStoreMem,
           IRd, RsA, RsB,
    output ODataA, ODataB, OWBValid, OWBRd, OWBData, ORetired
  );

endinterface

// File: rtl/wb_regfile_regfile_8x16.sv
// 8 x 16 architectural register storage: synchronous write with r0 suppressed,
// two asynchronous read ports, r0 always reads zero.
module regfile_8x16
  import wb_regfile_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] r_regs [NREGS];

  // NOTE: this array is small and architecturally required to clear on reset,
  // so it is built from flops with a reset loop rather than a RAM macro.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_regs[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_regs[i_raddr_b];

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects the write-back value, commits it to the register
// file, bypasses it to the decode read ports and counts retired writes.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic         CLK,
  input  logic         Reset,
  wb_regfile_if.slave  bus
);

  wb_sel_e           w_sel;
  logic [DATA_W-1:0] w_wb_data;
  logic              w_commit;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;
  logic [DATA_W-1:0] r_retired;

  // NOTE: w_wb_data gets a default before the case so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_sel     = wb_sel_decode(bus.ILink, bus.IRegStore);
    w_wb_data = '0;
    case (w_sel)
      WB_LINK: w_wb_data = bus.IPCP2;
      WB_MEM:  w_wb_data = bus.IStoreMem;
      default: w_wb_data = bus.IALUResult;
    endcase
    if (Reset) w_wb_data = '0;
  end

  // Writes to r0 are dropped entirely: no commit, no forwarding, no count.
  assign w_commit = bus.IRegWrite & bus.RegWrite & ~Reset & (bus.IRd != '0);

  regfile_8x16 u_regfile (
    .i_clk     (CLK),
    .i_rst     (Reset),
    .i_we      (w_commit),
    .i_waddr   (bus.IRd),
    .i_wdata   (w_wb_data),
    .i_raddr_a (bus.RsA),
    .i_raddr_b (bus.RsB),
    .o_rdata_a (w_rd_a),
    .o_rdata_b (w_rd_b)
  );

  // Same-cycle bypass; w_commit already excludes reset, stall and r0.
  assign bus.ODataA = (Reset || bus.RsA == '0) ? '0 :
                      (w_commit && bus.RsA == bus.IRd) ? w_wb_data : w_rd_a;
  assign bus.ODataB = (Reset || bus.RsB == '0) ? '0 :
                      (w_commit && bus.RsB == bus.IRd) ? w_wb_data : w_rd_b;

  assign bus.OWBValid = w_commit;
  assign bus.OWBRd    = Reset ? '0 : bus.IRd;
  assign bus.OWBData  = w_wb_data;
  assign bus.ORetired = r_retired;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_retired <= '0;
    end else if (w_commit) begin
      r_retired <= r_retired + DATA_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: directed and random write-back traffic
// checked against an array-based reference model.
module tb_wb_regfile;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_regfile_if bus ();

  wb_regfile dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] data_a;
    logic [15:0] data_b;
    logic        valid;
    logic [2:0]  rd;
    logic [15:0] wb_data;
    logic [15:0] retired;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  int   model_regs [8];
  int   model_retired = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares whatever the DUT presents mid-cycle with the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("ODataA",   32'(bus.ODataA),   32'(e.data_a));
      check("ODataB",   32'(bus.ODataB),   32'(e.data_b));
      check("OWBValid", 32'(bus.OWBValid), 32'(e.valid));
      check("OWBRd",    32'(bus.OWBRd),    32'(e.rd));
      check("OWBData",  32'(bus.OWBData),  32'(e.wb_data));
      check("ORetired", 32'(bus.ORetired), 32'(e.retired));
    end
  end

  // One clock cycle of stimulus; called at posedge+1, returns at next posedge+1.
  task automatic cyc(input logic r, input logic rw, input logic irw, input logic st,
                     input logic lk, input logic [15:0] pc, input logic [15:0] alu,
                     input logic [15:0] mem, input logic [2:0] rd,
                     input logic [2:0] ra, input logic [2:0] rb);
    exp_t e;
    int   wb;
    bit   commit;
    rst = r;
    bus.RegWrite = rw;  bus.IRegWrite = irw; bus.IRegStore = st; bus.ILink = lk;
    bus.IPCP2 = pc;     bus.IALUResult = alu; bus.IStoreMem = mem;
    bus.IRd = rd;       bus.RsA = ra;         bus.RsB = rb;

    commit = irw && rw && !r && (rd != 0);
    wb     = r ? 0 : lk ? int'(pc) : st ? int'(mem) : int'(alu);
    e.wb_data = 16'(wb);
    e.valid   = commit;
    e.rd      = r ? 3'd0 : rd;
    e.retired = 16'(model_retired);
    e.data_a  = (r || ra == 0) ? 16'h0 : (commit && ra == rd) ? 16'(wb) : 16'(model_regs[ra]);
    e.data_b  = (r || rb == 0) ? 16'h0 : (commit && rb == rd) ? 16'(wb) : 16'(model_regs[rb]);
    exp_q.push_back(e);

    @(posedge clk);
    if (r) begin
      foreach (model_regs[i]) model_regs[i] = 0;
      model_retired = 0;
    end else if (commit) begin
      model_regs[rd] = wb;
      model_retired  = (model_retired + 1) % 65536;
    end
    #1;
  endtask

  task automatic rd_only(input logic [2:0] ra, input logic [2:0] rb);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 3'd0, ra, rb);
  endtask

  initial begin
    foreach (model_regs[i]) model_regs[i] = 0;
    bus.RegWrite = 1'b0; bus.IRegWrite = 1'b0; bus.IRegStore = 1'b0; bus.ILink = 1'b0;
    bus.IPCP2 = '0; bus.IALUResult = '0; bus.IStoreMem = '0;
    bus.IRd = '0; bus.RsA = '0; bus.RsB = '0;
    // First reset edge is unchecked: ORetired is undefined until it.
    @(posedge clk); #1;

    // Fill r1..r7, then reset for one cycle and confirm everything reads zero.
    for (int i = 1; i < 8; i++)
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'($urandom), 16'h0, 3'(i), 3'(i), 3'(8 - i));
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd1, 3'd7);
    for (int i = 1; i < 8; i++) rd_only(3'(i), 3'(7 - i + 1));

    // Write-back select: ALU, memory, and link overriding memory.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h5678, 16'h0, 3'd3, 3'd0, 3'd0);
    rd_only(3'd3, 3'd3);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 16'h1111, 16'h9abc, 3'd4, 3'd3, 3'd0);
    rd_only(3'd4, 3'd3);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h2222, 16'h3333, 3'd5, 3'd4, 3'd3);
    rd_only(3'd5, 3'd4);

    // Bypass on both ports, then a stalled write to the same register.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'hBEEF, 16'h0, 3'd2, 3'd2, 3'd2);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h1111, 16'h0, 3'd2, 3'd2, 3'd2);
    rd_only(3'd2, 3'd2);

    // r0 writes are dropped.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'hFFFF, 16'h0, 3'd0, 3'd0, 3'd0);
    rd_only(3'd0, 3'd5);

    // Reset wins over a simultaneous write.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'hAAAA, 16'h0, 3'd6, 3'd6, 3'd6);
    rd_only(3'd6, 3'd6);

    // Random traffic with occasional stalls and resets.
    for (int n = 0; n < 500; n++)
      cyc(($urandom_range(31) == 0), ($urandom_range(7) != 0), 1'($urandom), 1'($urandom),
          ($urandom_range(3) == 0), 16'($urandom), 16'($urandom), 16'($urandom),
          3'($urandom), 3'($urandom), 3'($urandom));

    // Counter wrap: 65537 commits from zero leaves ORetired at 1.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0);
    for (int n = 0; n < 65537; n++)
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'($urandom), 16'h0, 3'd1, 3'd1, 3'($urandom));
    rd_only(3'd1, 3'd0);
    check("retired_after_wrap", 32'(bus.ORetired), 32'h1);

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
